// File: rtl/run_ctrl_monitor_if.sv
// Observation bus from the CPU to the run-control monitor: the commit stream
// and the register-file write port, both sampled on the monitor's clock.
interface run_ctrl_monitor_if #(
  parameter int XLEN = 32
);
  // No back-pressure: commit_valid is a one-cycle qualifier for commit_pc, and
  // rf_we qualifies rf_waddr/rf_wdata; the monitor never stalls the producer.
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  modport master (
    output commit_valid, commit_pc, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input commit_valid, commit_pc, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/run_ctrl_monitor.sv
// Run-control / watchdog: ends a test run on halt PC, watch-register value,
// cycle limit or stall. Optional PC trace ring buffer under RUN_CTRL_TRACE_EN.
module run_ctrl_monitor #(
  parameter int              XLEN         = 32,
  parameter int              CNT_W        = 16,
  parameter int unsigned     MAX_CYCLES   = 1000,
  parameter logic [XLEN-1:0] HALT_PC      = 32'hf0000100,
  parameter int unsigned     STALL_LIMIT  = 64,
  parameter int unsigned     DRAIN_CYCLES = 4,
  parameter int unsigned     WATCH_REG    = 31,
  parameter logic [XLEN-1:0] WATCH_VAL    = 32'h100,
  parameter int              DEPTH        = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  run_ctrl_monitor_if.slave          cpu,
  input  logic [$clog2(DEPTH)-1:0]   trace_sel,
  output logic [XLEN-1:0]            trace_data,
  output logic                       halted,
  output logic                       draining,
  output logic [2:0]                 halt_cause,
  output logic [CNT_W-1:0]           cycle_count,
  output logic [CNT_W-1:0]           retire_count,
  output logic [1:0]                 state_dbg
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam int     STALL_W   = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
  localparam int     DRW       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam longint CNT_RANGE = longint'(1) << CNT_W;
  // A limit beyond the saturating counter range could never be reached.
  localparam bit     T3_EN     = (MAX_CYCLES != 0) && (longint'(MAX_CYCLES) <= CNT_RANGE);
  localparam bit     T4_EN     = (STALL_LIMIT != 0);
  localparam bit     T2_EN     = (WATCH_REG != 0);
  localparam logic [DRW-1:0] DRAIN_LOAD =
    (DRAIN_CYCLES == 0) ? '0 : DRW'(DRAIN_CYCLES - 1);

  state_t             state_q, state_d;
  logic [2:0]         cause_q, cause_d;
  logic [DRW-1:0]     drain_q, drain_d;
  logic [STALL_W-1:0] stall_q;
  logic               active;
  logic               t1, t2, t3, t4;

  assign active = (state_q != S_HALT);

  assign t1 = cpu.commit_valid && (cpu.commit_pc == HALT_PC);
  assign t2 = T2_EN && cpu.rf_we && (cpu.rf_waddr == 5'(WATCH_REG)) &&
              (cpu.rf_wdata == WATCH_VAL);
  assign t3 = T3_EN && (cycle_count == CNT_W'(MAX_CYCLES - 1));
  assign t4 = T4_EN && (stall_q == STALL_W'(STALL_LIMIT - 1)) && !cpu.commit_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_RUN;
      cause_q <= 3'd0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      drain_q <= drain_d;
    end
  end

  // Triggers are only looked at in RUN; the cause is written once on the edge leaving RUN.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    drain_d = drain_q;
    case (state_q)
      S_RUN: begin
        if (t1 || t2) begin
          cause_d = t1 ? 3'd1 : 3'd2;
          if (DRAIN_CYCLES == 0) begin
            state_d = S_HALT;
          end else begin
            state_d = S_DRAIN;
            drain_d = DRAIN_LOAD;
          end
        end else if (t3) begin
          cause_d = 3'd3;
          state_d = S_HALT;
        end else if (t4) begin
          cause_d = 3'd4;
          state_d = S_HALT;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_HALT;
        else               drain_d = drain_q - DRW'(1);
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RUN;
    endcase
  end

  // Counters saturate at all-ones and freeze once halted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_count  <= '0;
      retire_count <= '0;
      stall_q      <= '0;
    end else if (active) begin
      if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
      if (cpu.commit_valid) begin
        if (retire_count != '1) retire_count <= retire_count + CNT_W'(1);
        stall_q <= '0;
      end else if (stall_q != '1) begin
        stall_q <= stall_q + STALL_W'(1);
      end
    end
  end

  assign halted     = (state_q == S_HALT);
  assign draining   = (state_q == S_DRAIN);
  assign halt_cause = cause_q;
  assign state_dbg  = state_q;

`ifdef RUN_CTRL_TRACE_EN
  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] trace_mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rd_idx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      for (int i = 0; i < DEPTH; i++) trace_mem[i] <= '0;
    end else if (active && cpu.commit_valid) begin
      trace_mem[wptr] <= cpu.commit_pc;
      wptr            <= wptr + AW'(1);
    end
  end

  // Index 0 is the newest entry; arithmetic wraps modulo DEPTH.
  assign rd_idx     = wptr - AW'(1) - trace_sel;
  assign trace_data = trace_mem[rd_idx];
`else
  logic unused_trace_sel;
  assign unused_trace_sel = ^trace_sel;
  assign trace_data       = '0;
`endif

endmodule

// File: doc/run_ctrl_monitor.md
Name: run_ctrl_monitor

Overview:
Synthesizable run-control and watchdog block placed in sccomp beside the pipelined CPU. Observes the commit stream and register-file write port. Decides when a test run ends and reports why, which replaces the ad-hoc stop logic currently held in simulation benches. Keeps cycle and retire counters and an optional ring buffer of recently committed PCs for post-mortem readout.

Parameters:
XLEN, 32, width of PC and register data
CNT_W, 16, width of cycle and retire counters
MAX_CYCLES, 1000, cycle limit; 0 disables the limit
HALT_PC, 32'hf0000100, committing this PC ends the run
STALL_LIMIT, 64, consecutive cycles without a commit before a stall halt; 0 disables it
DRAIN_CYCLES, 4, cycles waited after a halt trigger so in-flight writebacks complete
WATCH_REG, 31, register index watched for the end-of-test value
WATCH_VAL, 32'h100, value which, when written to WATCH_REG, ends the run
DEPTH, 8, trace buffer entries; must be a power of 2 and at least 2

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
commit_valid  in  1  one instruction retires this cycle
commit_pc  in  XLEN  PC of the retiring instruction
rf_we  in  1  register-file write enable (WB stage)
rf_waddr  in  5  register-file write index
rf_wdata  in  XLEN  register-file write data
trace_sel  in  $clog2(DEPTH)  trace readout index; 0 = newest entry
trace_data  out  XLEN  selected trace entry (combinational read)
halted  out  1  run finished; stays high until reset
draining  out  1  halt triggered, drain in progress
halt_cause  out  3  0 none, 1 halt PC, 2 watch match, 3 cycle limit, 4 stall
cycle_count  out  CNT_W  cycles since reset, saturating
retire_count  out  CNT_W  commits since reset, saturating

Behaviour:
- Reset (asynchronous, rstn low): FSM goes to RUN. halted=0, draining=0, halt_cause=0. All counters and trace entries are 0. The write pointer is 0.
- FSM states RUN, DRAIN, HALT.
- RUN: cycle_count increments every cycle. retire_count increments on commit_valid. The stall counter clears on commit_valid and otherwise increments.
- Triggers are evaluated each RUN cycle:
  - T1: commit_valid && commit_pc==HALT_PC.
  - T2: rf_we && rf_waddr==WATCH_REG && WATCH_REG!=0 && rf_wdata==WATCH_VAL.
  - T3: MAX_CYCLES!=0 && cycle_count==MAX_CYCLES-1.
  - T4: STALL_LIMIT!=0 && stall counter==STALL_LIMIT-1 && !commit_valid.
- Priority for simultaneous triggers: T1 > T2 > T3 > T4. halt_cause latches the winner on the trigger edge and never changes afterwards.
- T1/T2 move the FSM to DRAIN. draining=1 and the drain counter loads DRAIN_CYCLES-1. T1 and T2 go directly to HALT if DRAIN_CYCLES==0.
- T3/T4 move the FSM directly to HALT; the machine is considered hung.
- DRAIN: counters keep counting and commits are still traced. Further triggers are ignored. When the drain counter reaches 0, the next edge enters HALT.
- HALT: halted=1, draining=0. Counters and trace buffer freeze. Inputs are ignored. Exit only via rstn.
- Latency: halted rises DRAIN_CYCLES+1 edges after the T1/T2 trigger cycle, and 1 edge after a T3/T4 trigger cycle.
- Saturation: both counters hold at all-ones and never wrap.
- A commit in the trigger cycle is counted and traced.
- Reset asserted mid-DRAIN or in HALT clears everything immediately, with no wait for a clock.

Optional Feature:
Macro: RUN_CTRL_TRACE_EN.
- Defined: a DEPTH-entry ring buffer. Each commit_valid in RUN/DRAIN writes commit_pc at the write pointer, and the pointer increments modulo DEPTH (wraps, overwriting the oldest entry). trace_data = entry[(wptr-1-trace_sel) mod DEPTH]. Before DEPTH commits have occurred, unwritten entries read as 0.
- Undefined: no storage is built and trace_data is constant 0.

Test Plan:
1. Reset, then commit PCs 0,4,8,... one per cycle until commit_pc=f0000100 at the 10th commit, DRAIN_CYCLES=4 -> draining high for 4 cycles, then halted=1, halt_cause=1, retire_count=10.
2. rf write x31=0x100 in the same cycle as commit of HALT_PC -> halt_cause=1 (priority). A separate run with only the x31 write -> halt_cause=2. Writes of x31=0xFF or x0=0x100 -> no trigger.
3. MAX_CYCLES=1000, commits every cycle, no other trigger -> halted rises on the edge after cycle_count=999, halt_cause=3, no DRAIN.
4. STALL_LIMIT=64, commit_valid held low after 5 commits -> halted after the 64th idle cycle, halt_cause=4. A single commit at idle cycle 63 restarts the count.
5. With RUN_CTRL_TRACE_EN, DEPTH=8, commit 12 PCs 0x0..0x2C -> trace_sel=0 reads 0x2C, trace_sel=7 reads 0x10. Without the macro, all selects read 0.
6. Pulse rstn low mid-DRAIN, asynchronously between clock edges -> draining, halted, halt_cause and both counters read 0 before the next edge. A subsequent run behaves as in scenario 1.
